// File: rtl/result_uart_tx.sv
// UART transmitter that serialises one DATA_W-bit result word as DATA_W/8 8N1 frames,
// most-significant byte first, least-significant bit first within each byte.
module result_uart_tx #(
    parameter int DATA_W       = 256,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_Tx,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              done,
    output logic              Tx
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BYTE_W = $clog2(NBYTES + 1);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [BAUD_W-1:0]   baud_r, baud_s;
    logic [2:0]          bit_r, bit_s;
    logic [BYTE_W-1:0]   byte_idx_r, byte_idx_s;
    logic [DATA_W-1:0]   shift_r, shift_s;
    logic                tx_r, tx_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    logic                load_s;
    logic                bit_end_s;
    logic [7:0]          byte_s;
    logic [2:0]          bit_inc_s;

    assign load_s    = in_valid && en_Tx && !busy_r;
    assign bit_end_s = (baud_r == BAUD_LAST);
    // The byte on the wire always sits in the top 8 bits of the shift register.
    assign byte_s    = shift_r[DATA_W-1 -: 8];
    assign bit_inc_s = bit_r + 3'd1;

    // Next-state and next-output logic; line value is computed one cycle ahead so Tx is a flop.
    always_comb begin
        state_s    = state_r;
        baud_s     = baud_r;
        bit_s      = bit_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        tx_s       = tx_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (load_s) begin
                    state_s    = S_START;
                    shift_s    = Q;
                    baud_s     = {BAUD_W{1'b0}};
                    bit_s      = 3'd0;
                    byte_idx_s = {BYTE_W{1'b0}};
                    tx_s       = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    tx_s   = 1'b1;
                    busy_s = 1'b0;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_DATA;
                    baud_s  = {BAUD_W{1'b0}};
                    bit_s   = 3'd0;
                    tx_s    = byte_s[0];
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (!bit_end_s) begin
                    baud_s = baud_r + BAUD_W'(1);
                end else if (bit_r == 3'd7) begin
                    state_s = S_STOP;
                    baud_s  = {BAUD_W{1'b0}};
                    bit_s   = 3'd0;
                    tx_s    = 1'b1;
                end else begin
                    baud_s = {BAUD_W{1'b0}};
                    bit_s  = bit_inc_s;
                    tx_s   = byte_s[bit_inc_s];
                end
            end
            S_STOP: begin
                if (!bit_end_s) begin
                    baud_s = baud_r + BAUD_W'(1);
                end else if (byte_idx_r == BYTE_LAST) begin
                    state_s = S_IDLE;
                    baud_s  = {BAUD_W{1'b0}};
                    tx_s    = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    // Next start bit follows the stop bit with no idle gap.
                    state_s    = S_START;
                    baud_s     = {BAUD_W{1'b0}};
                    byte_idx_s = byte_idx_r + BYTE_W'(1);
                    shift_s    = shift_r << 4'd8;
                    tx_s       = 1'b0;
                end
            end
            default: begin
                state_s    = S_IDLE;
                baud_s     = {BAUD_W{1'b0}};
                bit_s      = 3'd0;
                byte_idx_s = {BYTE_W{1'b0}};
                tx_s       = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            bit_r      <= 3'd0;
            byte_idx_r <= {BYTE_W{1'b0}};
            shift_r    <= {DATA_W{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_r     <= baud_s;
            bit_r      <= bit_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Tx   = tx_r;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: a 16-bit instance for framing, ignore, enable,
// back-to-back and reset cases, and a 256-bit instance for the long-word case.
module tb_result_uart_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en16, iv16, busy16, done16, tx16;
    logic [15:0]  q16;
    logic         en256, iv256, busy256, done256, tx256;
    logic [255:0] q256;

    int checks_total  = 0;
    int checks_passed = 0;
    int done_cnt16    = 0;
    int done_cnt256   = 0;

    result_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(4)) dut16 (
        .clock(clk), .reset(rst_n), .en_Tx(en16), .in_valid(iv16),
        .Q(q16), .busy(busy16), .done(done16), .Tx(tx16)
    );

    result_uart_tx #(.DATA_W(256), .CLKS_PER_BIT(4)) dut256 (
        .clock(clk), .reset(rst_n), .en_Tx(en256), .in_valid(iv256),
        .Q(q256), .busy(busy256), .done(done256), .Tx(tx256)
    );

    always #5 clk = ~clk;

    // Count done pulses on each instance.
    always @(posedge clk) begin
        if (done16)  done_cnt16  <= done_cnt16 + 1;
        if (done256) done_cnt256 <= done_cnt256 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else checks_passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level c cycles after the load edge, 4 cycles per bit, MSB byte first.
    function automatic logic exp_tx(input logic [255:0] w, input int nbytes, input int c);
        int b, byt, pos;
        logic [255:0] sh;
        logic [7:0] by;
        b   = c / 4;
        byt = b / 10;
        pos = b % 10;
        sh  = w >> (8 * (nbytes - 1 - byt));
        by  = sh[7:0];
        if (pos == 0) return 1'b0;
        else if (pos == 9) return 1'b1;
        else return by[3'(pos - 1)];
    endfunction

    // Called in the first cycle after a load; ends in the done cycle.
    task automatic check_word(input bit wide, input logic [255:0] w, input int nbytes,
                              input int poke, input logic [15:0] poke_q, input bit keep,
                              input string tag);
        int total;
        total = nbytes * 40;
        for (int c = 0; c < total; c++) begin
            logic t, b, d;
            if (wide) begin t = tx256; b = busy256; d = done256; end
            else begin t = tx16; b = busy16; d = done16; end
            check_eq({tag, "_tx"}, {31'd0, t}, {31'd0, exp_tx(w, nbytes, c)});
            check_eq({tag, "_busy_done"}, {30'd0, b, d}, 32'd2);
            if (!wide) begin
                if (c + 1 == poke) begin
                    iv16 = 1'b1;
                    q16  = poke_q;
                end else begin
                    iv16 = keep;
                end
            end
            tick();
        end
        if (wide) begin
            check_eq({tag, "_end_tx"}, {31'd0, tx256}, 32'd1);
            check_eq({tag, "_end_busy_done"}, {30'd0, busy256, done256}, 32'd1);
        end else begin
            check_eq({tag, "_end_tx"}, {31'd0, tx16}, 32'd1);
            check_eq({tag, "_end_busy_done"}, {30'd0, busy16, done16}, 32'd1);
        end
    endtask

    task automatic check_idle16(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_eq({tag, "_idle_tx"}, {31'd0, tx16}, 32'd1);
            check_eq({tag, "_idle_busy_done"}, {30'd0, busy16, done16}, 32'd0);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en16  = 1'b1; iv16  = 1'b0; q16  = 16'h0000;
        en256 = 1'b1; iv256 = 1'b0; q256 = 256'd0;
        tick(); tick();
        check_eq("rst_tx", {31'd0, tx16}, 32'd1);
        check_eq("rst_busy_done", {30'd0, busy16, done16}, 32'd0);
        check_eq("rst_tx256", {31'd0, tx256}, 32'd1);
        rst_n = 1'b1;
        check_idle16("post_rst", 3);

        // Reset asserted mid-idle and held.
        rst_n = 1'b0;
        #1;
        check_idle16("t1_during", 3);
        rst_n = 1'b1;
        check_idle16("t1_after", 3);

        // Single word, plus an ignored load attempt at cycle 30.
        q16 = 16'h3CA5; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        check_word(1'b0, 256'h3CA5, 2, 30, 16'hFFFF, 1'b0, "t2");
        tick();
        check_eq("t3_done_cnt", done_cnt16, 32'd1);
        check_idle16("t3", 5);

        // Load blocked while disabled, then accepted; disabling mid-word has no effect.
        en16 = 1'b0; iv16 = 1'b1; q16 = 16'h1234;
        check_idle16("t4_blocked", 20);
        en16 = 1'b1;
        tick();
        iv16 = 1'b0; en16 = 1'b0;
        check_word(1'b0, 256'h1234, 2, 0, 16'h0000, 1'b0, "t4");
        tick();
        en16 = 1'b1;
        check_idle16("t4", 3);

        // in_valid held high: each done cycle reloads straight into the next start bit.
        q16 = 16'h0102; iv16 = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) begin
            check_word(1'b0, 256'h0102, 2, 0, 16'h0000, 1'b1, "t5");
            if (w == 2) iv16 = 1'b0;
            tick();
        end
        check_eq("t5_done_cnt", done_cnt16, 32'd5);
        check_idle16("t5", 3);

        // Reset in cycle 45 of a word, then a fresh word.
        q16 = 16'h3CA5; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        for (int i = 1; i < 45; i++) tick();
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tx", {31'd0, tx16}, 32'd1);
        check_eq("t6_rst_busy_done", {30'd0, busy16, done16}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        check_idle16("t6_release", 6);
        q16 = 16'hC35A; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        check_word(1'b0, 256'hC35A, 2, 0, 16'h0000, 1'b0, "t6_after");
        tick();

        // 256-bit word: 31 zero bytes then A5.
        q256 = {248'h0, 8'hA5}; iv256 = 1'b1;
        tick();
        iv256 = 1'b0;
        q256 = {256{1'b1}};
        check_word(1'b1, {248'h0, 8'hA5}, 32, 0, 16'h0000, 1'b0, "t7");
        tick();
        check_eq("t7_done_cnt", done_cnt256, 32'd1);
        check_eq("t7_idle_tx", {31'd0, tx256}, 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
